alu_shift_arbiter: RTL and testbench
====================================

// Module: alu_shift_arbiter
// PURPOSE
//  Shares one shift/rotate datapath (SLL, SAR, ROL, ROR) among NUM_REQ requesters.
//  Round-robin arbitration; operands and opcode registered on grant; result returned on a
//  valid/ready response channel tagged with the requester id.
//  Sits between the issue logic of several ALU clients and the shift execution resource.
// PARAMETERS
//  WIDTH    32  operand/result width in bits; power of two, >= 8
//  NUM_REQ  4   number of requesters, 2..8
//  ID_W     $clog2(NUM_REQ)  width of rsp_id (derived, not overridable)
// PORTS
//  clk        in   1              single clock, all state on rising edge
//  rst_n      in   1              asynchronous assert, active-low reset
//  req_valid  in   NUM_REQ        per-requester request valid
//  req_ready  out  NUM_REQ        per-requester accept, one-hot or zero
//  req_a      in   NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NUM_REQ*WIDTH  shift amount source, same packing
//  req_op     in   NUM_REQ*4      opcode, requester i at [i*4 +: 4]
//  rsp_valid  out  1              response valid
//  rsp_ready  in   1              response accept
//  rsp_data   out  WIDTH          result
//  rsp_id     out  ID_W           index of the requester that owns rsp_data
//  rsp_err    out  1              opcode was not SLL/SAR/ROL/ROR; rsp_data is 0
//  busy       out  1              high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0,
//   req_ready=0. Reset mid-operation drops the in-flight op with no response.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: req_ready[w]=1 only for the winner w, only when |req_valid. Handshake at cycle N
//    latches A, B, op and id=w, advances the rr pointer to w+1 mod NUM_REQ, goes to EXEC.
//   EXEC: computes the result, registers rsp_data, rsp_id and rsp_err, sets rsp_valid, goes to RESP.
//   RESP: holds rsp_* stable while rsp_ready=0. On rsp_ready=1, rsp_valid=0 next cycle,
//    goes to IDLE.
//  Timing: rsp_valid rises at N+2. Back-to-back throughput is one op per 3 cycles minimum.
//  req_ready is combinational from state, pointer and req_valid; no ready->valid path.
//  Arbitration: the first valid requester at or after the pointer, in increasing index order,
//   with wrap. A requester dropping req_valid without a handshake is legal; nothing is latched.
//  Datapath: sh = B[$clog2(WIDTH)-1:0], i.e. B mod WIDTH. The upper bits of B are ignored.
//   SLL 4'b0101: A << sh
//   SAR 4'b0110: $signed(A) >>> sh
//   ROL 4'b0111: (A << sh) | (A >> (WIDTH-sh)); sh=0 yields A
//   ROR 4'b1000: (A >> sh) | (A << (WIDTH-sh)); sh=0 yields A
//   Other op: rsp_data=0, rsp_err=1, still a normal response.
//  Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req_valid and are
//   served in rr order. No requester waits more than NUM_REQ-1 grants.
// STRUCTURE
//  Package alu_pkg: opcode localparams OPCODE_SLL/SAR/ROTATIONLEFT/ROTATIONRIGHT,
//   state enum alu_arb_state_e {IDLE, EXEC, RESP}.
//  Sub-module rr_arbiter #(N): req vector and pointer in, one-hot grant and grant index out,
//   purely combinational.
//  Pointer register, FSM, operand and response registers and the shift mux live in the top.
// TESTING (WIDTH=32, NUM_REQ=4)
//  Single requester: req1 SLL A=0x0000_0001 B=4 -> req_ready[1] at N, rsp at N+2 with
//   data=0x0000_0010, id=1, err=0.
//  Rotate and wrap of shift amount: ROL A=0x8000_0001 B=1 -> 0x0000_0003. ROR same A, B=33
//   -> 0xC000_0000. ROL B=0 -> A.
//  SAR sign: A=0xF000_0000 B=4 -> 0xFF00_0000. Bad op 4'b1111 -> data=0, err=1.
//  Fairness: all 4 req_valid held high -> grants in order 0,1,2,3,0. Grant is never 2 cycles
//   apart and never twice in a row.
//  Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, busy=1. After release,
//   next grant 1 cycle after the response handshake.
//  Async reset in EXEC -> all outputs 0 immediately; no response for the dropped op. Pointer
//   restarts at 0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes and FSM state type for the shift arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OPCODE_SLL           = 4'b0101;
    localparam logic [3:0] OPCODE_SAR           = 4'b0110;
    localparam logic [3:0] OPCODE_ROTATIONLEFT  = 4'b0111;
    localparam logic [3:0] OPCODE_ROTATIONRIGHT = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first asserted request at or
//               after the pointer, searching upward with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        int w_pos;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = IDW'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_arbiter
// Description : One shift/rotate unit (SLL, SAR, ROL, ROR) shared by NUM_REQ
//               requesters with round-robin grant and a tagged valid/ready
//               response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shift_arbiter
    import alu_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]     req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int SH_W = $clog2(WIDTH);

    alu_arb_state_e     r_state;
    alu_arb_state_e     w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [WIDTH-1:0]   r_a;
    logic [SH_W-1:0]    r_sh;
    logic [3:0]         r_op;
    logic [ID_W-1:0]    r_id;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [ID_W-1:0]    r_rsp_id;
    logic               r_rsp_err;

    logic [WIDTH-1:0]   w_a_arr  [NUM_REQ];
    logic [SH_W-1:0]    w_sh_arr [NUM_REQ];
    logic [3:0]         w_op_arr [NUM_REQ];
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic               w_take;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [SH_W-1:0]    w_nsh;
    logic [WIDTH-1:0]   w_res;
    logic               w_err;
    logic               w_unused_b;

    // Only B mod WIDTH matters; the upper bits of each B are intentionally dropped.
    assign w_unused_b = ^req_b;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
            assign w_sh_arr[gi] = req_b[gi*WIDTH +: SH_W];
            assign w_op_arr[gi] = req_op[gi*4 +: 4];
        end
    endgenerate

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // A grant happens in every IDLE cycle that has at least one valid request.
    assign w_take    = (r_state == IDLE) && w_any;
    assign req_ready = (w_take && rst_n) ? w_gnt : '0;
    assign w_ptr_nxt = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> EXEC on grant, EXEC -> RESP, RESP -> IDLE on accept.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture the winner's operands and advance the round-robin pointer past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_sh  <= '0;
            r_op  <= '0;
            r_id  <= '0;
            r_ptr <= '0;
        end else if (w_take) begin
            r_a   <= w_a_arr[w_idx];
            r_sh  <= w_sh_arr[w_idx];
            r_op  <= w_op_arr[w_idx];
            r_id  <= w_idx;
            r_ptr <= w_ptr_nxt;
        end
    end

    // Rotates use the complementary amount modulo WIDTH, which is 0 when sh is 0.
    assign w_nsh = -r_sh;

    // Shift/rotate mux; unknown opcodes yield zero data and the error flag.
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (r_op)
            OPCODE_SLL:           w_res = r_a << r_sh;
            OPCODE_SAR:           w_res = $signed(r_a) >>> r_sh;
            OPCODE_ROTATIONLEFT:  w_res = (r_a << r_sh) | (r_a >> w_nsh);
            OPCODE_ROTATIONRIGHT: w_res = (r_a >> r_sh) | (r_a << w_nsh);
            default:              w_err = 1'b1;
        endcase
    end

    // Response registers: loaded in EXEC, held in RESP until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rsp_err   <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_res;
            r_rsp_id    <= r_id;
            r_rsp_err   <= w_err;
        end else if ((r_state == RESP) && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_shift_arbiter
// Description : Scoreboard bench for alu_shift_arbiter (WIDTH=32, NUM_REQ=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_shift_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N*4-1:0]   req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [1:0]       rsp_id;
    logic             rsp_err;
    logic             busy;

    alu_shift_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   id;
        logic         err;
        int           gcycle;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_ptr    = 0;
    bit   m_busy   = 1'b0;
    int   p_req    = 0;
    int   p_rdy    = 100;
    int   s_gnt;
    logic         s_rsp_valid;
    logic [W-1:0] s_rsp_data;
    logic [1:0]   s_rsp_id;
    logic         s_rsp_err;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        failures++;
        $display("FAIL %s bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference: shift amount is B mod 32; shifts/rotates done one bit at a time.
    function automatic logic [W-1:0] ref_calc(logic [3:0] op, logic [W-1:0] a,
                                              logic [W-1:0] b, output logic err);
        int sh;
        logic [W-1:0] r;
        sh  = int'(b % W);
        r   = a;
        err = 1'b0;
        case (op)
            4'b0101: repeat (sh) r = r + r;
            4'b0110: r = a[W-1] ? ~((~a) >> sh) : (a >> sh);
            4'b0111: repeat (sh) r = {r[W-2:0], r[W-1]};
            4'b1000: repeat (sh) r = {r[0], r[W-1:1]};
            default: begin r = '0; err = 1'b1; end
        endcase
        return r;
    endfunction

    task automatic rand_drive();
        logic [3:0] op;
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && (int'($urandom % 100) < p_req)) begin
                case ($urandom % 6)
                    0: op = 4'b0101;
                    1: op = 4'b0110;
                    2: op = 4'b0111;
                    3: op = 4'b1000;
                    4: op = 4'($urandom);
                    default: op = 4'h0;
                endcase
                req_a[i*W +: W] = $urandom;
                req_b[i*W +: W] = $urandom;
                req_op[i*4 +: 4] = op;
                req_valid[i] = 1'b1;
            end
        end
        rsp_ready = int'($urandom % 100) < p_rdy;
    endtask

    // One cycle: drive at negedge, sample 1 time unit later, update the model.
    task automatic step();
        logic [N-1:0] exp_rdy;
        int   w;
        exp_t e;
        logic err;
        rand_drive();
        #1;
        exp_rdy = '0;
        w = -1;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && req_valid[j]) w = j;
            end
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(m_busy));
        s_gnt       = w;
        s_rsp_valid = rsp_valid;
        s_rsp_data  = rsp_data;
        s_rsp_id    = rsp_id;
        s_rsp_err   = rsp_err;
        if (w >= 0) begin
            e.data   = ref_calc(req_op[w*4 +: 4], req_a[w*W +: W], req_b[w*W +: W], err);
            e.err    = err;
            e.id     = 2'(w);
            e.gcycle = cyc;
            q.push_back(e);
            m_ptr  = (w + 1) % N;
            m_busy = 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            m_busy = 1'b0;
        end
        @(negedge clk);
        if (w >= 0) req_valid[w] = 1'b0;
    endtask

    task automatic issue(int i, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req_op[i*4 +: 4] = op;
        req_valid[i]     = 1'b1;
        for (int t = 0; t < 30; t++) begin
            step();
            if (s_gnt == i) return;
        end
        fail_now("issue_grant");
    endtask

    // Monitor: compares every presented response against the queue head.
    bit r_seen = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && rsp_valid) begin
                if (q.size() == 0) begin
                    fail_now("rsp_unexpected");
                end else begin
                    e = q[0];
                    if (!r_seen) begin
                        chk("rsp_latency", 64'(cyc), 64'(e.gcycle + 2));
                        r_seen = 1'b1;
                    end
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        r_seen = 1'b0;
                    end
                end
            end
        end
    end

    logic [3:0]   d_op  [6] = '{4'b0101, 4'b0111, 4'b1000, 4'b0111, 4'b0110, 4'b1111};
    logic [W-1:0] d_a   [6] = '{32'h0000_0001, 32'h8000_0001, 32'h8000_0001,
                                32'h1234_5678, 32'hF000_0000, 32'hDEAD_BEEF};
    logic [W-1:0] d_b   [6] = '{32'd4, 32'd1, 32'd33, 32'd0, 32'd4, 32'd7};
    logic [W-1:0] d_res [6] = '{32'h0000_0010, 32'h0000_0003, 32'hC000_0000,
                                32'h1234_5678, 32'hFF00_0000, 32'h0000_0000};
    int           d_req [6] = '{1, 0, 2, 3, 1, 2};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed operations with known results.
        p_req = 0;
        p_rdy = 100;
        for (int k = 0; k < 6; k++) begin
            issue(d_req[k], d_op[k], d_a[k], d_b[k]);
            step();
            step();
            chk("dir_rsp_valid", 64'(s_rsp_valid), 64'd1);
            chk("dir_rsp_data", 64'(s_rsp_data), 64'(d_res[k]));
            chk("dir_rsp_id", 64'(s_rsp_id), 64'(d_req[k]));
            chk("dir_rsp_err", 64'(s_rsp_err), 64'(k == 5));
        end

        // Fairness: every requester continuously valid.
        p_req = 100;
        for (int k = 0; k < 16; k++) step();

        // Backpressure: hold off the response for several cycles.
        p_rdy = 0;
        for (int k = 0; k < 10; k++) step();
        p_rdy = 100;
        for (int k = 0; k < 6; k++) step();

        // Random traffic.
        p_req = 40;
        p_rdy = 70;
        for (int k = 0; k < 600; k++) step();

        // Asynchronous reset while an operation is in EXEC.
        p_req = 0;
        p_rdy = 100;
        for (int t = 0; t < 100 && (req_valid != 0 || m_busy); t++) step();
        issue(1, 4'b0101, 32'h0000_1234, 32'd3);
        #3;
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst_rsp_data", 64'(rsp_data), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd0);
        q.delete();
        m_ptr  = 0;
        m_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_ptr_restart", 64'(s_gnt), 64'd0);

        p_req = 40;
        p_rdy = 70;
        for (int k = 0; k < 150; k++) step();

        // Drain outstanding work.
        p_req = 0;
        p_rdy = 100;
        for (int t = 0; t < 100 && (req_valid != 0 || m_busy || q.size() != 0); t++) step();
        if (req_valid != 0 || m_busy || q.size() != 0) fail_now("drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
